// File: rtl/sram_be_pipe.sv
// ---------------------------------------------------------------------------
// sram_be_pipe
//   Single-port SRAM model with per-byte write enables, a request/grant
//   handshake and a configurable read-latency pipeline. This is the data and
//   tag store behind the icache controller.
//
//   After reset the array can be zeroed by a hardware sweep that clears one
//   word per cycle. Requests are granted only once that sweep has finished.
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   rst_i        asynchronous reset, active-high
//   req_i        request valid; accepted when req_i & gnt_o
//   gnt_o        high in READY, low while the clear sweep runs
//   we_i         1 = write, 0 = read
//   addr_i       word address
//   be_i         byte enables for writes (ignored on reads)
//   wdata_i      write data
//   rvalid_o     rdata_o valid this cycle
//   rdata_o      read data; holds its last value while idle
//   init_done_o  clear sweep complete, array usable
// ---------------------------------------------------------------------------
module sram_be_pipe #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned NUM_WORDS      = 1024,
  parameter int unsigned ADDR_WIDTH     = $clog2(NUM_WORDS),
  parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  init_done_o
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH:0]   NUM_WORDS_W = (ADDR_WIDTH + 1)'(NUM_WORDS);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q;
  logic [DATA_WIDTH-1:0]   mem_q [NUM_WORDS];

  logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_vld_q;

  logic                    accept;
  logic                    in_range;
  logic                    do_write;
  logic                    do_read;
  logic [DATA_WIDTH-1:0]   rd_word;

  // Handshake and address decode. NUM_WORDS need not be a power of two, so
  // addresses above the last word are possible and must be filtered.
  always_comb begin
    gnt_o       = (state_q == ST_READY);
    init_done_o = (state_q == ST_READY);
    accept      = req_i & gnt_o;
    in_range    = ({1'b0, addr_i} < NUM_WORDS_W);
    do_write    = accept & we_i & in_range;
    do_read     = accept & ~we_i;
    rd_word     = '0;
    if (in_range) begin
      rd_word = mem_q[addr_i];
    end
  end

  // Clear-sweep FSM: INIT walks the counter over every word, READY is final.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= CLEAR_ON_RESET ? ST_INIT : ST_READY;
      clr_cnt_q <= '0;
    end else if (state_q == ST_INIT) begin
      if (clr_cnt_q == LAST_ADDR) begin
        state_q <= ST_READY;
      end else begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
      end
    end
  end

  // Storage has no reset of its own; the sweep (or the user) initialises it.
  // Writes are suppressed while rst_i is held so reset never alters contents.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == ST_INIT) begin
        mem_q[clr_cnt_q] <= '0;
      end else if (do_write) begin
        for (int unsigned b = 0; b < BE_WIDTH; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end
    end
  end

  // Read pipeline. Each data stage only loads when valid data arrives, so the
  // final stage (and thus rdata_o) keeps its last value while idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld_q <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= do_read;
      if (do_read) begin
        pipe_data_q[0] <= rd_word;
      end
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        if (pipe_vld_q[i-1]) begin
          pipe_data_q[i] <= pipe_data_q[i-1];
        end
      end
    end
  end

  always_comb begin
    rvalid_o = pipe_vld_q[READ_LATENCY-1];
    rdata_o  = pipe_data_q[READ_LATENCY-1];
  end

endmodule

// File: tb/tb_sram_be_pipe.sv
// ---------------------------------------------------------------------------
// tb_sram_be_pipe
//   Drives two sram_be_pipe instances with a shared request stream:
//     u_a : 12 words (non-power-of-two), READ_LATENCY = 1
//     u_b : 16 words,                    READ_LATENCY = 3
//   Read expectations are queued when a request is driven and popped when
//   the matching rvalid_o appears, checking data and arrival cycle.
// ---------------------------------------------------------------------------
module tb_sram_be_pipe;

  localparam int NW_A = 12;
  localparam int NW_B = 16;
  localparam int RL_A = 1;
  localparam int RL_B = 3;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  typedef struct {
    bit          req;
    bit          we;
    logic [3:0]  addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  addr  = '0;
  logic [7:0]  be    = '0;
  logic [63:0] wdata = '0;

  logic        gnt_a, rvalid_a, done_a;
  logic [63:0] rdata_a;
  logic        gnt_b, rvalid_b, done_b;
  logic [63:0] rdata_b;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   edges    = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  vec_t tbl[$];

  sram_be_pipe #(
    .DATA_WIDTH     (64),
    .NUM_WORDS      (NW_A),
    .READ_LATENCY   (RL_A),
    .CLEAR_ON_RESET (1'b1)
  ) u_a (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .gnt_o       (gnt_a),
    .we_i        (we),
    .addr_i      (addr),
    .be_i        (be),
    .wdata_i     (wdata),
    .rvalid_o    (rvalid_a),
    .rdata_o     (rdata_a),
    .init_done_o (done_a)
  );

  sram_be_pipe #(
    .DATA_WIDTH     (64),
    .NUM_WORDS      (NW_B),
    .READ_LATENCY   (RL_B),
    .CLEAR_ON_RESET (1'b1)
  ) u_b (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .gnt_o       (gnt_b),
    .we_i        (we),
    .addr_i      (addr),
    .be_i        (be),
    .wdata_i     (wdata),
    .rvalid_o    (rvalid_b),
    .rdata_o     (rdata_b),
    .init_done_o (done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edges since reset release; the sweep for an N-word array spans N edges.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Grant / init_done follow the sweep length exactly.
  always @(negedge clk) begin
    chk("gnt_a",  {63'b0, gnt_a},  {63'b0, (!rst && edges >= NW_A)});
    chk("done_a", {63'b0, done_a}, {63'b0, (!rst && edges >= NW_A)});
    chk("gnt_b",  {63'b0, gnt_b},  {63'b0, (!rst && edges >= NW_B)});
    chk("done_b", {63'b0, done_b}, {63'b0, (!rst && edges >= NW_B)});
  end

  always @(negedge clk) begin
    if (rvalid_a) begin
      if (q_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_rvalid_unexpected: got rvalid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e_a = q_a.pop_front();
        chk("a_rdata",   rdata_a,     e_a.data);
        chk("a_latency", 64'(cyc),    64'(e_a.due));
      end
    end else if (q_a.size() != 0 && q_a[0].due <= cyc) begin
      e_a = q_a.pop_front();
      n_checks++; n_fail++;
      $display("FAIL a_rvalid_missing: got rvalid=0 expected 1 (cycle %0d)", cyc);
    end
  end

  always @(negedge clk) begin
    if (rvalid_b) begin
      if (q_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_rvalid_unexpected: got rvalid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e_b = q_b.pop_front();
        chk("b_rdata",   rdata_b,     e_b.data);
        chk("b_latency", 64'(cyc),    64'(e_b.due));
      end
    end else if (q_b.size() != 0 && q_b[0].due <= cyc) begin
      e_b = q_b.pop_front();
      n_checks++; n_fail++;
      $display("FAIL b_rvalid_missing: got rvalid=0 expected 1 (cycle %0d)", cyc);
    end
  end

  // Present one request for the next rising edge and queue read results for
  // each instance that the bench expects to grant it.
  task automatic drive(input bit r, input bit w, input logic [3:0] a, input logic [7:0] b,
                       input logic [63:0] d, input logic [63:0] ea, input logic [63:0] eb);
    @(negedge clk);
    req = r; we = w; addr = a; be = b; wdata = d;
    if (r && !w && edges >= NW_A) q_a.push_back('{ea, cyc + RL_A});
    if (r && !w && edges >= NW_B) q_b.push_back('{eb, cyc + RL_B});
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 8'h00, 64'h0, 64'h0, 64'h0);
  endtask

  function automatic void row(input bit r, input bit w, input logic [3:0] a, input logic [7:0] b,
                              input logic [63:0] d, input logic [63:0] ea, input logic [63:0] eb);
    tbl.push_back('{r, w, a, b, d, ea, eb});
  endfunction

  initial begin
    // Read rows carry expected data; write rows leave it zero.
    row(1, 1, 4'd3,  8'hFF, 64'h1122334455667788, 64'h0, 64'h0);
    row(1, 1, 4'd3,  8'h0F, 64'hAAAAAAAAAAAAAAAA, 64'h0, 64'h0);
    row(1, 0, 4'd3,  8'h00, 64'h0, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA);
    row(1, 1, 4'd3,  8'h00, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0);
    row(1, 0, 4'd3,  8'h00, 64'h0, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA);
    row(0, 0, 4'd0,  8'h00, 64'h0, 64'h0, 64'h0);
    row(1, 1, 4'd0,  8'hFF, 64'hA0A0A0A000000000, 64'h0, 64'h0);
    row(1, 1, 4'd1,  8'hFF, 64'hA1A1A1A111111111, 64'h0, 64'h0);
    row(1, 1, 4'd2,  8'hFF, 64'hA2A2A2A222222222, 64'h0, 64'h0);
    row(1, 1, 4'd3,  8'hFF, 64'hA3A3A3A333333333, 64'h0, 64'h0);
    row(1, 0, 4'd0,  8'h00, 64'h0, 64'hA0A0A0A000000000, 64'hA0A0A0A000000000);
    row(1, 0, 4'd1,  8'h00, 64'h0, 64'hA1A1A1A111111111, 64'hA1A1A1A111111111);
    row(1, 0, 4'd2,  8'h00, 64'h0, 64'hA2A2A2A222222222, 64'hA2A2A2A222222222);
    row(1, 0, 4'd3,  8'h00, 64'h0, 64'hA3A3A3A333333333, 64'hA3A3A3A333333333);
    row(1, 1, 4'd5,  8'h03, 64'h000000000000DEAD, 64'h0, 64'h0);
    row(1, 0, 4'd5,  8'h00, 64'h0, 64'h000000000000DEAD, 64'h000000000000DEAD);
    row(1, 1, 4'd6,  8'hA5, 64'h8877665544332211, 64'h0, 64'h0);
    row(1, 0, 4'd6,  8'h00, 64'h0, 64'h8800660000330011, 64'h8800660000330011);
    row(1, 1, 4'd13, 8'hFF, 64'h00000000000000FF, 64'h0, 64'h0);
    row(1, 0, 4'd13, 8'h00, 64'h0, 64'h0, 64'h00000000000000FF);
    row(1, 1, 4'd12, 8'hFF, 64'hCCCCCCCCCCCCCCCC, 64'h0, 64'h0);
    row(1, 0, 4'd12, 8'h00, 64'h0, 64'h0, 64'hCCCCCCCCCCCCCCCC);
    row(1, 1, 4'd11, 8'hF0, 64'h5555555555555555, 64'h0, 64'h0);
    row(1, 0, 4'd11, 8'h00, 64'h0, 64'h5555555500000000, 64'h5555555500000000);
    row(1, 0, 4'd15, 8'h00, 64'h0, 64'h0, 64'h0);

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rvalid_a", {63'b0, rvalid_a}, 64'h0);
    chk("rst_rdata_a",  rdata_a,           64'h0);
    chk("rst_rvalid_b", {63'b0, rvalid_b}, 64'h0);
    chk("rst_rdata_b",  rdata_b,           64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Requests during the sweep must have no effect: writes of all-ones and
    // reads that must not produce rvalid.
    for (int i = 0; i < 10; i++)
      drive(1'b1, (i % 2) == 0, 4'(i), 8'hFF, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0);
    repeat (NW_B) idle();

    // Every word reads as zero after the sweep (out-of-range words too).
    for (int i = 0; i < 16; i++)
      drive(1'b1, 1'b0, 4'(i), 8'h00, 64'h0, 64'h0, 64'h0);

    foreach (tbl[i])
      drive(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata, tbl[i].exp_a, tbl[i].exp_b);

    // rdata_o keeps the last read value once the pipeline drains.
    drive(1'b1, 1'b0, 4'd5, 8'h00, 64'h0, 64'h000000000000DEAD, 64'h000000000000DEAD);
    repeat (6) idle();
    #1;
    chk("hold_rvalid_a", {63'b0, rvalid_a}, 64'h0);
    chk("hold_rdata_a",  rdata_a,           64'h000000000000DEAD);
    chk("hold_rvalid_b", {63'b0, rvalid_b}, 64'h0);
    chk("hold_rdata_b",  rdata_b,           64'h000000000000DEAD);

    // Reset with a read still inside u_b's pipeline: it must be discarded.
    drive(1'b1, 1'b0, 4'd3, 8'h00, 64'h0, 64'hA3A3A3A333333333, 64'hA3A3A3A333333333);
    idle();
    #2;
    rst = 1'b1;
    q_b.delete();
    #1;
    chk("inflight_rst_rvalid_b", {63'b0, rvalid_b}, 64'h0);
    chk("inflight_rst_rdata_b",  rdata_b,           64'h0);
    chk("inflight_rst_rdata_a",  rdata_a,           64'h0);
    chk("inflight_rst_gnt_b",    {63'b0, gnt_b},    64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of the sweep restarts it from word zero.
    repeat (7) idle();
    #2;
    rst = 1'b1;
    #1;
    chk("midsweep_gnt_a",    {63'b0, gnt_a},    64'h0);
    chk("midsweep_gnt_b",    {63'b0, gnt_b},    64'h0);
    chk("midsweep_rvalid_b", {63'b0, rvalid_b}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (NW_B) idle();

    // Words written before the resets were cleared by the completed sweep.
    drive(1'b1, 1'b0, 4'd3,  8'h00, 64'h0, 64'h0, 64'h0);
    drive(1'b1, 1'b0, 4'd5,  8'h00, 64'h0, 64'h0, 64'h0);
    drive(1'b1, 1'b0, 4'd13, 8'h00, 64'h0, 64'h0, 64'h0);
    drive(1'b1, 1'b0, 4'd11, 8'h00, 64'h0, 64'h0, 64'h0);
    repeat (8) idle();

    if (q_a.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL a_drain: got %0d outstanding reads expected 0", q_a.size());
    end
    if (q_b.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL b_drain: got %0d outstanding reads expected 0", q_b.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
